fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter AW, default 15, frame-buffer address width.
REQ-002 Parameter DW, default 8, pixel width (RGB332).
REQ-003 Parameter WBUF_DEPTH, default 4, write-buffer entries, power of two, at least 2.
REQ-004 Parameter URGENT, default 3, buffer occupancy at which writes outrank reads.
REQ-005 pclk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 wr_req  in  1  camera pixel write strobe (one pulse per pixel, never stalls).
REQ-008 wr_addr  in  AW  camera write address.
REQ-009 wr_data  in  DW  camera write pixel.
REQ-010 rd_req  in  1  display read request, held until rd_ack.
REQ-011 rd_addr  in  AW  display read address, stable while rd_req is high.
REQ-012 rd_ack  out  1  one-cycle pulse: read issued to memory.
REQ-013 rd_data  out  DW  read pixel.
REQ-014 rd_valid  out  1  one-cycle pulse: rd_data valid.
REQ-015 mem_en  out  1  memory port enable.
REQ-016 mem_we  out  1  memory write enable.
REQ-017 mem_addr  out  AW  memory address.
REQ-018 mem_din  out  DW  memory write data.
REQ-019 mem_dout  in  DW  memory read data, valid one cycle after a read is issued.
REQ-020 wr_ovf  out  1  sticky flag: a camera write was dropped.
REQ-021 ovf_clr  in  1  synchronous clear of wr_ovf.

Function
REQ-022 Each cycle with wr_req=1, {wr_addr, wr_data} SHALL be pushed into a FIFO of WBUF_DEPTH entries.
REQ-023 Push with the FIFO full and no pop in the same cycle SHALL drop the pixel and set wr_ovf; push and pop in the same cycle on a full FIFO SHALL accept the push.
REQ-024 Arbitration each cycle, in strict priority: (a) occupancy >= URGENT -> WRITE; (b) rd_req=1 and no rd_ack in the current cycle -> READ; (c) occupancy > 0 -> WRITE; (d) otherwise IDLE.
REQ-025 WRITE decided at edge k SHALL pop the FIFO head and drive mem_en=1, mem_we=1, mem_addr/mem_din=head for exactly the cycle after edge k.
REQ-026 READ decided at edge k SHALL drive mem_en=1, mem_we=0, mem_addr=rd_addr and rd_ack=1 for exactly the cycle after edge k.
REQ-027 rd_data SHALL be registered from mem_dout, and rd_valid SHALL pulse, exactly 2 cycles after the rd_ack cycle.
REQ-028 At most one memory access SHALL be issued per cycle; mem_en=0 and mem_we=0 when IDLE.
REQ-029 Writes SHALL reach memory in FIFO (arrival) order; no entry is reordered or duplicated.
REQ-030 Back-to-back reads SHALL be legal: with rd_req held high, a second rd_ack SHALL occur no earlier than 2 cycles after the first.
REQ-031 ovf_clr=1 SHALL clear wr_ovf; an overflow in the same cycle SHALL win and leave wr_ovf=1.
REQ-032 Address and data widths SHALL pass through unchanged; no arithmetic on addresses.

Reset
REQ-033 While rst=0: FIFO empty, state IDLE, and all outputs (rd_ack, rd_valid, rd_data, mem_en, mem_we, mem_addr, mem_din, wr_ovf) SHALL be 0.
REQ-034 Reset mid-operation SHALL discard buffered writes, and an in-flight read SHALL NOT produce rd_valid.
REQ-035 The first arbitration decision SHALL occur at the first rising pclk edge after rst deasserts.

Configuration
REQ-036 With macro FB_ARBITER_STATS_EN defined: output rd_stall_cnt [15:0] SHALL count cycles with rd_req=1 and rd_ack=0, saturate at 0xFFFF, and reset to 0 on rst=0 or ovf_clr=1.
REQ-037 Without FB_ARBITER_STATS_EN: the rd_stall_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-038 Single write, wr_addr=0x0010, wr_data=0xA5, idle reader -> 1 cycle later mem_en=1, mem_we=1, mem_addr=0x0010, mem_din=0xA5; wr_ovf=0.
REQ-039 Read of rd_addr=0x0020 with mem model returning 0x3C -> rd_ack 1 cycle after request, rd_valid=1 with rd_data=0x3C 2 cycles after rd_ack.
REQ-040 rd_req held high while wr_req pulses every cycle for 6 cycles -> reads are served until occupancy reaches 3, then writes take priority; all 6 pixels are written in order; wr_ovf=0.
REQ-041 wr_req held high for 8 cycles while the memory port is blocked by urgent writes with depth 4 -> no pixel is dropped (one pop per cycle); forcing 5 pushes with no pops -> wr_ovf=1; ovf_clr pulse -> wr_ovf=0.
REQ-042 rst=0 asserted with 3 buffered writes and one read in flight -> outputs 0 immediately, no rd_valid, and no buffered writes after release.
REQ-043 With FB_ARBITER_STATS_EN defined, rd_req held for 10 cycles under urgent writes -> rd_stall_cnt=10; ovf_clr pulse -> rd_stall_cnt=0.

Source files
------------

// File: rtl/fb_arbiter_if.sv
// fb_arbiter_if: camera-write, display-read and memory-port signal bundle for fb_arbiter
interface fb_arbiter_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          wr_ovf;
    logic          ovf_clr;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_dout, ovf_clr,
        input  rd_ack, rd_data, rd_valid, mem_en, mem_we, mem_addr, mem_din, wr_ovf
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, mem_dout, ovf_clr,
        output rd_ack, rd_data, rd_valid, mem_en, mem_we, mem_addr, mem_din, wr_ovf
    );
endinterface

// File: rtl/fb_arbiter.sv
// fb_arbiter: camera-write FIFO and display-read arbiter for a single-port frame buffer
// Optional macro FB_ARBITER_STATS_EN adds the rd_stall_cnt read-stall counter output.
module fb_arbiter #(
    parameter int AW         = 15,
    parameter int DW         = 8,
    parameter int WBUF_DEPTH = 4,
    parameter int URGENT     = 3
) (
    input  logic        pclk,
    input  logic        rst,
    fb_arbiter_if.slave bus
`ifdef FB_ARBITER_STATS_EN
    ,
    output logic [15:0] rd_stall_cnt
`endif
);
    localparam int PW = $clog2(WBUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t           state_q, state_d;
    logic [AW+DW-1:0] buf_q [WBUF_DEPTH];
    logic [AW+DW-1:0] buf_d [WBUF_DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    din_q, din_d, rdata_q, rdata_d;
    logic             rdp_q, rdp_d, rvalid_q, rvalid_d, ovf_q, ovf_d;
    logic [31:0]      occ;
    logic [AW+DW-1:0] head;
    logic             pop, push, full, drop;

    assign occ  = 32'(cnt_q);
    assign head = buf_q[rptr_q];

    // decision register: which access (if any) the memory port carries this cycle
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // strict priority: urgent write, read (never right after its own ack), pending write, idle
    always_comb begin
        state_d = occ >= 32'(URGENT)              ? WRITE :
                  (bus.rd_req && state_q != READ) ? READ  :
                  occ != 0                        ? WRITE : IDLE;
    end

    // memory-port and reader outputs decoded from the registered decision
    always_comb begin
        bus.mem_en   = state_q != IDLE;
        bus.mem_we   = state_q == WRITE;
        bus.rd_ack   = state_q == READ;
        bus.mem_addr = addr_q;
        bus.mem_din  = din_q;
        bus.rd_data  = rdata_q;
        bus.rd_valid = rvalid_q;
        bus.wr_ovf   = ovf_q;
    end

    // FIFO bookkeeping, access address/data capture and read-return pipeline
    always_comb begin
        pop   = state_d == WRITE;
        full  = occ == 32'(WBUF_DEPTH);
        push  = bus.wr_req && (!full || pop);
        drop  = bus.wr_req && full && !pop;
        buf_d = buf_q;
        if (push) buf_d[wptr_q] = {bus.wr_addr, bus.wr_data};
        wptr_d   = wptr_q + PW'(push);
        rptr_d   = rptr_q + PW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        addr_d   = state_d == WRITE ? head[DW +: AW] :
                   state_d == READ  ? bus.rd_addr    : addr_q;
        din_d    = state_d == WRITE ? head[DW-1:0] : din_q;
        rdp_d    = state_q == READ;
        rvalid_d = rdp_q;
        rdata_d  = rdp_q ? bus.mem_dout : rdata_q;
        ovf_d    = drop ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf_q;
    end

    // datapath registers; reset drops buffered pixels and any read in flight
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            buf_q    <= '{default: '0};
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            rdp_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            buf_q    <= buf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rdp_q    <= rdp_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            ovf_q    <= ovf_d;
        end
    end

`ifdef FB_ARBITER_STATS_EN
    logic [15:0] stall_q, stall_d;

    // saturating count of cycles the reader waits without an ack, cleared with the overflow flag
    always_comb begin
        stall_d = bus.ovf_clr ? 16'd0 :
                  (bus.rd_req && state_q != READ && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end

    // stall counter register
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign rd_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: vector table, directed corner sequences and random traffic against a queue model
module tb_fb_arbiter;
    localparam int AW  = 15;
    localparam int DW  = 8;
    localparam int D   = 4;
    localparam int URG = 3;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    typedef struct {
        logic          wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          rd;
        logic [AW-1:0] ra;
        logic          clr;
        logic          en, we, ack, vld, ovf;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed, er;
    } vec_t;

    logic pclk = 1'b0;
    logic rst  = 1'b0;
    logic chk_en = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 pclk = ~pclk;

    fb_arbiter_if #(.AW(AW), .DW(DW)) bus  ();
    fb_arbiter_if #(.AW(AW), .DW(DW)) bus2 ();

`ifdef FB_ARBITER_STATS_EN
    logic [15:0] stall_cnt, stall_cnt2;
`endif

    fb_arbiter #(.AW(AW), .DW(DW), .WBUF_DEPTH(D), .URGENT(URG)) dut (
        .pclk(pclk), .rst(rst), .bus(bus)
`ifdef FB_ARBITER_STATS_EN
        , .rd_stall_cnt(stall_cnt)
`endif
    );

    // second instance whose writes never become urgent, so the buffer can overflow
    fb_arbiter #(.AW(AW), .DW(DW), .WBUF_DEPTH(D), .URGENT(8)) dut2 (
        .pclk(pclk), .rst(rst), .bus(bus2)
`ifdef FB_ARBITER_STATS_EN
        , .rd_stall_cnt(stall_cnt2)
`endif
    );

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h1C;
    endfunction

    // memory: read data for the address presented last cycle
    always @(posedge pclk) begin
        bus.mem_dout  <= memf(bus.mem_addr);
        bus2.mem_dout <= memf(bus2.mem_addr);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t          mq[$];
    logic          m_en, m_we, m_ack, m_ovf, m_valid, p_ack;
    logic [AW-1:0] m_addr, p_addr;
    logic [DW-1:0] m_din, m_rdata;
    logic [15:0]   m_stall;

    task automatic model_reset();
        mq.delete();
        {m_en, m_we, m_ack, m_ovf, m_valid, p_ack} = '0;
        m_addr = '0; p_addr = '0; m_din = '0; m_rdata = '0; m_stall = '0;
    endtask

    task automatic model_step();
        int   occ = mq.size();
        logic ack_now = m_ack;
        int   dec;
        ent_t e;
        m_valid = p_ack;
        if (p_ack) m_rdata = memf(p_addr);
        p_ack  = m_ack;
        p_addr = m_addr;
        if (bus.ovf_clr) m_stall = '0;
        else if (bus.rd_req && !ack_now && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
        dec = occ >= URG ? 1 : (bus.rd_req && !ack_now) ? 2 : occ > 0 ? 1 : 0;
        m_en  = dec != 0;
        m_we  = dec == 1;
        m_ack = dec == 2;
        if (dec == 1) begin
            e = mq.pop_front();
            m_addr = e.a;
            m_din  = e.d;
        end else if (dec == 2) begin
            m_addr = bus.rd_addr;
        end
        if (bus.wr_req) begin
            if (mq.size() < D) mq.push_back({bus.wr_addr, bus.wr_data});
            else m_ovf = 1'b1;
        end else if (bus.ovf_clr) m_ovf = 1'b0;
        if (bus.wr_req && mq.size() < D && bus.ovf_clr && occ < D) m_ovf = 1'b0;
    endtask

    always @(negedge rst) model_reset();

    always @(posedge pclk) begin
        if (!rst) model_reset();
        else model_step();
    end

    always @(negedge pclk) begin
        if (chk_en) begin
            chk("m_ctrl", {bus.rd_ack, bus.rd_valid, bus.mem_en, bus.mem_we, bus.wr_ovf},
                {m_ack, m_valid, m_en, m_we, m_ovf});
            if (m_en) chk("m_addr", bus.mem_addr, m_addr);
            if (m_we) chk("m_din", bus.mem_din, m_din);
            if (m_valid) chk("m_rdata", bus.rd_data, m_rdata);
`ifdef FB_ARBITER_STATS_EN
            chk("m_stall", stall_cnt, m_stall);
`endif
        end
    end

    // writes seen on the memory port, in order
    ent_t wlog[$];
    always @(negedge pclk) if (bus.mem_en && bus.mem_we) wlog.push_back({bus.mem_addr, bus.mem_din});

    task automatic wait_ack_drop();
        for (int k = 0; k < 20 && !bus.rd_ack; k++) @(negedge pclk);
        chk("ack_wait", bus.rd_ack, 1);
        bus.rd_req = 1'b0;
    endtask

    task automatic chk_writes(input string nm, input ent_t exp_w[$]);
        chk({nm, "_count"}, wlog.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wlog.size(); i++) chk({nm, "_order"}, wlog[i], exp_w[i]);
    endtask

    vec_t tbl [9];
    ent_t exp_w[$];

    initial begin
        tbl[0] = '{1, 15'h010, 8'hA5, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 0, 0, 0, 0,            1, 1, 0, 0, 0, 15'h010, 8'hA5, 0};
        tbl[2] = '{0, 0, 0, 1, 15'h020, 0,      1, 0, 1, 0, 0, 15'h020, 0, 0};
        tbl[3] = '{0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4] = '{0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, 0, 8'h3C};
        tbl[5] = '{1, 15'h123, 8'h77, 1, 15'h040, 0, 1, 0, 1, 0, 0, 15'h040, 0, 0};
        tbl[6] = '{0, 0, 0, 0, 0, 0,            1, 1, 0, 0, 0, 15'h123, 8'h77, 0};
        tbl[7] = '{0, 0, 0, 0, 0, 0,            0, 0, 0, 1, 0, 0, 0, 8'h5C};
        tbl[8] = '{0, 0, 0, 0, 0, 1,            0, 0, 0, 0, 0, 0, 0, 0};

        {bus.wr_req, bus.rd_req, bus.ovf_clr} = '0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        {bus2.wr_req, bus2.rd_req, bus2.ovf_clr} = '0;
        bus2.wr_addr = '0; bus2.wr_data = '0; bus2.rd_addr = '0;

        repeat (3) @(negedge pclk);
        chk("rst_ctrl", {bus.rd_ack, bus.rd_valid, bus.mem_en, bus.mem_we, bus.wr_ovf}, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_din", bus.mem_din, 0);
        chk("rst_rdata", bus.rd_data, 0);
        chk("rst_ctrl2", {bus2.rd_ack, bus2.rd_valid, bus2.mem_en, bus2.mem_we, bus2.wr_ovf}, 0);
        rst = 1'b1;
        chk_en = 1'b1;

        // directed vectors: single write, single read, read beating a fresh write, overflow clear
        for (int i = 0; i < 9; i++) begin
            bus.wr_req = tbl[i].wr; bus.wr_addr = tbl[i].wa; bus.wr_data = tbl[i].wd;
            bus.rd_req = tbl[i].rd; bus.rd_addr = tbl[i].ra; bus.ovf_clr = tbl[i].clr;
            @(negedge pclk);
            chk($sformatf("vec%0d_ctrl", i), {bus.rd_ack, bus.rd_valid, bus.mem_en, bus.mem_we, bus.wr_ovf},
                {tbl[i].ack, tbl[i].vld, tbl[i].en, tbl[i].we, tbl[i].ovf});
            if (tbl[i].en) chk($sformatf("vec%0d_addr", i), bus.mem_addr, tbl[i].ea);
            if (tbl[i].we) chk($sformatf("vec%0d_din", i), bus.mem_din, tbl[i].ed);
            if (tbl[i].vld) chk($sformatf("vec%0d_rdata", i), bus.rd_data, tbl[i].er);
        end
        {bus.wr_req, bus.rd_req, bus.ovf_clr} = '0;
        repeat (4) @(negedge pclk);

        // reader held while six pixels arrive back to back
        wlog.delete(); exp_w.delete();
        bus.rd_req = 1'b1; bus.rd_addr = 15'h0155;
        for (int i = 0; i < 6; i++) begin
            bus.wr_req = 1'b1; bus.wr_addr = AW'(15'h200 + i); bus.wr_data = DW'($urandom);
            exp_w.push_back({bus.wr_addr, bus.wr_data});
            @(negedge pclk);
        end
        bus.wr_req = 1'b0;
        repeat (4) @(negedge pclk);
        wait_ack_drop();
        repeat (6) @(negedge pclk);
        chk_writes("mixed", exp_w);
        chk("mixed_ovf", bus.wr_ovf, 0);

        // eight pixels back to back with an idle reader: one pop per cycle, nothing dropped
        wlog.delete(); exp_w.delete();
        for (int i = 0; i < 8; i++) begin
            bus.wr_req = 1'b1; bus.wr_addr = AW'($urandom); bus.wr_data = DW'($urandom);
            exp_w.push_back({bus.wr_addr, bus.wr_data});
            @(negedge pclk);
        end
        bus.wr_req = 1'b0;
        repeat (4) @(negedge pclk);
        chk_writes("burst", exp_w);
        chk("burst_ovf", bus.wr_ovf, 0);

        // random traffic, reader obeys hold-until-ack
        for (int i = 0; i < 800; i++) begin
            bus.wr_req = (i < 400) ? ($urandom_range(1, 0) == 0) : ($urandom_range(2, 0) != 0);
            bus.wr_addr = AW'($urandom); bus.wr_data = DW'($urandom);
            bus.ovf_clr = $urandom_range(15, 0) == 0;
            if (bus.rd_req) begin
                if (bus.rd_ack && $urandom_range(1, 0) == 0) bus.rd_req = 1'b0;
            end else if ($urandom_range(3, 0) == 0) begin
                bus.rd_req = 1'b1; bus.rd_addr = AW'($urandom);
            end
            @(negedge pclk);
        end
        {bus.wr_req, bus.ovf_clr} = '0;
        if (bus.rd_req) wait_ack_drop();
        repeat (8) @(negedge pclk);

        // reset with three buffered pixels and a read in flight
        bus.rd_req = 1'b1; bus.rd_addr = 15'h0077;
        for (int i = 0; i < 5; i++) begin
            bus.wr_req = 1'b1; bus.wr_addr = AW'(15'h300 + i); bus.wr_data = DW'(i);
            @(negedge pclk);
        end
        chk("pre_rst_ack", bus.rd_ack, 1);
        {bus.wr_req, bus.rd_req} = '0;
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_ctrl", {bus.rd_ack, bus.rd_valid, bus.mem_en, bus.mem_we, bus.wr_ovf}, 0);
        chk("mid_rst_addr", bus.mem_addr, 0);
        chk("mid_rst_din", bus.mem_din, 0);
        chk("mid_rst_rdata", bus.rd_data, 0);
        @(negedge pclk);
        rst = 1'b1;
        begin
            int acts = 0;
            for (int i = 0; i < 8; i++) begin
                @(negedge pclk);
                acts += int'(bus.mem_en) + int'(bus.rd_valid);
            end
            chk("post_rst_quiet", acts, 0);
        end

        // overflow on the non-urgent instance: reads every other cycle, one push per cycle
        bus2.rd_req = 1'b1; bus2.rd_addr = 15'h0011; bus2.wr_req = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            bus2.wr_addr = AW'(i); bus2.wr_data = DW'(i);
            bus2.ovf_clr = (i == 12 || i == 13);
            @(negedge pclk);
            if (i == 8)  chk("ovf_before_full", bus2.wr_ovf, 0);
            if (i == 9)  chk("ovf_set", bus2.wr_ovf, 1);
            if (i == 12) chk("ovf_cleared", bus2.wr_ovf, 0);
            if (i == 13) chk("ovf_beats_clr", bus2.wr_ovf, 1);
        end
        chk("ovf2_ack", bus2.rd_ack, 1);
        {bus2.rd_req, bus2.wr_req, bus2.ovf_clr} = '0;
        repeat (6) @(negedge pclk);

`ifdef FB_ARBITER_STATS_EN
        // stall counter clears on ovf_clr
        bus.rd_req = 1'b1; bus.rd_addr = 15'h0042;
        @(negedge pclk);
        chk("stall_counted", stall_cnt, 1);
        wait_ack_drop();
        bus.ovf_clr = 1'b1;
        @(negedge pclk);
        bus.ovf_clr = 1'b0;
        chk("stall_cleared", stall_cnt, 0);
        repeat (4) @(negedge pclk);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
